// File: rtl/wb_ram32_bridge.sv
// Wishbone classic slave in front of the single-port ram32 word memory.
// Byte-lane writes are done as an internal read-modify-write since ram32 has no byte enables.
module wb_ram32_bridge #(
    parameter int unsigned RAM_SIZE = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              wb_adr_i,
    input  logic [31:0]              wb_dat_i,
    input  logic [3:0]               wb_sel_i,
    input  logic                     wb_we_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    output logic [31:0]              wb_dat_o,
    output logic                     wb_ack_o,
    output logic [$clog2(RAM_SIZE/4)-1:0] ram_addr,
    output logic                     ram_ce,
    output logic                     ram_we,
    output logic [31:0]              ram_wdata,
    input  logic [31:0]              ram_rdata
);

    localparam int unsigned RAM_ADDR_BITS = $clog2(RAM_SIZE / 4);

    typedef enum logic [2:0] {StIdle, StRd, StRdw, StWr, StAck} state_e;

    state_e                   state_q;
    logic [RAM_ADDR_BITS-1:0] adr_q;
    logic [31:0]              wdat_q;
    logic [3:0]               sel_q;
    logic                     we_q;
    logic [31:0]              rdat_q;
    logic [31:0]              merged;

    // Bits outside the word index are don't-care; upper bits give modulo aliasing.
    logic unused_adr;
    assign unused_adr = ^{wb_adr_i[31:RAM_ADDR_BITS+2], wb_adr_i[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            adr_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            rdat_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        adr_q  <= wb_adr_i[RAM_ADDR_BITS+1:2];
                        wdat_q <= wb_dat_i;
                        sel_q  <= wb_sel_i;
                        we_q   <= wb_we_i;
                        if (!wb_we_i) begin
                            state_q <= StRd;
                        end else if (wb_sel_i == 4'hF) begin
                            state_q <= StWr;
                        end else if (wb_sel_i == 4'h0) begin
                            state_q <= StAck;
                        end else begin
                            state_q <= StRd;
                        end
                    end
                end
                StRd: state_q <= StRdw;
                StRdw: begin
                    if (!we_q) begin
                        rdat_q <= ram_rdata;
                    end
                    state_q <= StAck;
                end
                StWr:    state_q <= StAck;
                StAck:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            merged[8*n +: 8] = sel_q[n] ? wdat_q[8*n +: 8] : ram_rdata[8*n +: 8];
        end
    end

    always_comb begin
        ram_ce    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (!reset) begin
            case (state_q)
                StRd: begin
                    ram_ce   = 1'b1;
                    ram_addr = adr_q;
                end
                StRdw: begin
                    if (we_q) begin
                        ram_ce    = 1'b1;
                        ram_we    = 1'b1;
                        ram_addr  = adr_q;
                        ram_wdata = merged;
                    end
                end
                StWr: begin
                    ram_ce    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = adr_q;
                    ram_wdata = wdat_q;
                end
                default: ;
            endcase
        end
    end

    // Ack follows cyc so a master that abandons the cycle never sees a stray ack.
    assign wb_ack_o = (state_q == StAck) && wb_cyc_i && !reset;
    assign wb_dat_o = rdat_q;

endmodule
